blankport_stim: RTL and testbench

Stimulus generator and response compactor for the blank-port harness. It drives pseudo-random 4-bit `a`/`b` vectors into the harness inputs, waits a programmable settle time, and samples the harness's 8-bit `o` output. Each sample is folded into a 16-bit MISR signature. The block is the driving end of the harness interface and gives systest runs a single signature to compare across translation flows.

---
 rtl/blankport_stim_if.sv | 22 ++
 rtl/blankport_stim.sv | 94 +++++++++
 tb/tb_blankport_stim.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/blankport_stim_if.sv
// Harness-side bus of the blank-port stimulus block: drive vectors out, response in,
// plus run status and the compacted signature.
interface blankport_stim_if;
    logic        start;
    logic [7:0]  o;
    logic [3:0]  a;
    logic [3:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] sig;
    logic [7:0]  vec_cnt;

    modport master (
        input  start, o,
        output a, b, busy, done, sig, vec_cnt
    );

    modport slave (
        output start, o,
        input  a, b, busy, done, sig, vec_cnt
    );
endinterface

// File: rtl/blankport_stim.sv
// Pseudo-random a/b stimulus generator with settle delay; each sampled response o is
// folded into a 16-bit MISR signature.
module blankport_stim #(
    parameter int         COUNT  = 16,
    parameter int         SETTLE = 1,
    parameter logic [7:0] SEED   = 8'hA5
) (
    input logic              clk,
    input logic              rst_n,
    blankport_stim_if.master bus
);
    typedef enum logic [2:0] {IDLE, DRIVE, WAIT, SAMPLE, DONE} state_t;

    state_t      state;
    logic [7:0]  lfsr;
    logic [15:0] sig;
    logic [7:0]  vec_cnt;
    logic [3:0]  wait_cnt;
    logic        busy;
    logic        done;

    logic        lfsr_fb;
    logic        misr_fb;
    logic [7:0]  cnt_inc;

    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
    assign misr_fb = sig[15] ^ sig[4] ^ sig[2] ^ sig[1];
    assign cnt_inc = vec_cnt + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            lfsr     <= SEED;
            sig      <= 16'h0000;
            vec_cnt  <= 8'h00;
            wait_cnt <= 4'h0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        lfsr    <= SEED;
                        sig     <= 16'h0000;
                        vec_cnt <= 8'h00;
                        busy    <= 1'b1;
                        state   <= DRIVE;
                    end
                end
                DRIVE: begin
                    if (SETTLE == 0) begin
                        state <= SAMPLE;
                    end else begin
                        wait_cnt <= 4'(SETTLE - 1);
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    // counter starts at SETTLE-1, so WAIT spans exactly SETTLE cycles
                    if (wait_cnt == 4'h0) state <= SAMPLE;
                    else                  wait_cnt <= wait_cnt - 4'h1;
                end
                SAMPLE: begin
                    sig     <= {sig[14:0], misr_fb} ^ {8'h00, bus.o};
                    vec_cnt <= cnt_inc;
                    lfsr    <= {lfsr[6:0], lfsr_fb};
                    if (cnt_inc == 8'(COUNT)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        state <= DRIVE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.a       = lfsr[7:4];
    assign bus.b       = lfsr[3:0];
    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.sig     = sig;
    assign bus.vec_cnt = vec_cnt;
endmodule

// File: tb/tb_blankport_stim.sv
// Bench for blankport_stim: several parameterizations share clk/rst_n, each scenario
// task checks against LFSR/MISR arithmetic and the run-timing rules.
module tb_blankport_stim;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    blankport_stim_if i1 ();
    blankport_stim_if i2 ();
    blankport_stim_if i3 ();
    blankport_stim_if i4 ();
    blankport_stim_if i5 ();

    blankport_stim #(.COUNT(1),  .SETTLE(0), .SEED(8'hA5)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1));
    blankport_stim #(.COUNT(2),  .SETTLE(0), .SEED(8'hA5)) u2 (.clk(clk), .rst_n(rst_n), .bus(i2));
    blankport_stim #(.COUNT(1),  .SETTLE(3), .SEED(8'hA5)) u3 (.clk(clk), .rst_n(rst_n), .bus(i3));
    blankport_stim #(.COUNT(16), .SETTLE(1), .SEED(8'hA5)) u4 (.clk(clk), .rst_n(rst_n), .bus(i4));
    blankport_stim #(.COUNT(5),  .SETTLE(2), .SEED(8'h3B)) u5 (.clk(clk), .rst_n(rst_n), .bus(i5));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [7:0] d);
        return {s[14:0], s[15] ^ s[4] ^ s[2] ^ s[1]} ^ {8'h00, d};
    endfunction

    // Asynchronous reset mid-cycle after a completed run on u1.
    task automatic test_reset();
        i1.o = 8'h77;
        @(negedge clk); i1.start = 1'b1;
        @(posedge clk); #1; i1.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if (i1.sig !== 16'h0077) begin n_bad++; $display("FAIL reset_pre_sig: got %h want 0077", i1.sig); end
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({i1.a, i1.b} !== 8'hA5) begin n_bad++; $display("FAIL reset_ab: got %h want a5", {i1.a, i1.b}); end
        n_cmp++;
        if (i1.sig !== 16'h0000) begin n_bad++; $display("FAIL reset_sig: got %h want 0000", i1.sig); end
        n_cmp++;
        if (i1.vec_cnt !== 8'h00) begin n_bad++; $display("FAIL reset_cnt: got %h want 00", i1.vec_cnt); end
        n_cmp++;
        if ({i1.busy, i1.done} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: got %b want 00", {i1.busy, i1.done}); end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_single();
        int busy_n, done_at;
        busy_n = 0; done_at = -1;
        i1.o = 8'h3C;
        @(negedge clk); i1.start = 1'b1;
        @(posedge clk); #1; i1.start = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (i1.busy) busy_n++;
            if (i1.done && done_at < 0) done_at = c;
        end
        n_cmp++;
        if (busy_n !== 2) begin n_bad++; $display("FAIL single_busy: got %0d want 2", busy_n); end
        n_cmp++;
        if (done_at !== 3) begin n_bad++; $display("FAIL single_done: got %0d want 3", done_at); end
        n_cmp++;
        if (i1.sig !== 16'h003C) begin n_bad++; $display("FAIL single_sig: got %h want 003c", i1.sig); end
        n_cmp++;
        if (i1.vec_cnt !== 8'd1) begin n_bad++; $display("FAIL single_cnt: got %0d want 1", i1.vec_cnt); end
        n_cmp++;
        if ({i1.a, i1.b} !== 8'h4A) begin n_bad++; $display("FAIL single_ab: got %h want 4a", {i1.a, i1.b}); end
    endtask

    task automatic test_two();
        int done_at;
        logic [7:0] ab3;
        done_at = -1; ab3 = 8'h00;
        i2.o = 8'h3C;
        @(negedge clk); i2.start = 1'b1;
        @(posedge clk); #1; i2.start = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (c == 3) ab3 = {i2.a, i2.b};
            if (i2.done && done_at < 0) done_at = c;
        end
        n_cmp++;
        if (ab3 !== 8'h4A) begin n_bad++; $display("FAIL two_vec2_ab: got %h want 4a", ab3); end
        n_cmp++;
        if (i2.sig !== 16'h0044) begin n_bad++; $display("FAIL two_sig: got %h want 0044", i2.sig); end
        n_cmp++;
        if ({i2.a, i2.b} !== 8'h95) begin n_bad++; $display("FAIL two_ab: got %h want 95", {i2.a, i2.b}); end
        n_cmp++;
        if (done_at !== 5) begin n_bad++; $display("FAIL two_done: got %0d want 5", done_at); end
    endtask

    task automatic test_settle();
        int done_at;
        done_at = -1;
        i3.o = 8'h00;
        @(negedge clk); i3.start = 1'b1;
        @(posedge clk); #1; i3.start = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            if (c == 4) i3.o = 8'hFF;
            if (i3.done && done_at < 0) done_at = c;
        end
        n_cmp++;
        if (i3.sig !== 16'h00FF) begin n_bad++; $display("FAIL settle_sig: got %h want 00ff", i3.sig); end
        n_cmp++;
        if (done_at !== 6) begin n_bad++; $display("FAIL settle_done: got %0d want 6", done_at); end
    endtask

    task automatic test_start_ignored();
        int busy_n, done_n;
        busy_n = 0; done_n = 0;
        i3.o = 8'h5A;
        @(negedge clk); i3.start = 1'b1;
        @(posedge clk); #1; i3.start = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            i3.start = (c == 3 || c == 6);
            if (i3.busy) busy_n++;
            if (i3.done) done_n++;
        end
        n_cmp++;
        if (busy_n !== 5) begin n_bad++; $display("FAIL ign_busy: got %0d want 5", busy_n); end
        n_cmp++;
        if (done_n !== 1) begin n_bad++; $display("FAIL ign_done: got %0d want 1", done_n); end
        n_cmp++;
        if (i3.sig !== 16'h005A) begin n_bad++; $display("FAIL ign_hold_sig: got %h want 005a", i3.sig); end
        @(negedge clk); i3.start = 1'b1;
        @(posedge clk); #1; i3.start = 1'b0;
        n_cmp++;
        if ({i3.sig, i3.vec_cnt} !== 24'h0) begin n_bad++; $display("FAIL ign_restart_clr: got %h want 000000", {i3.sig, i3.vec_cnt}); end
        n_cmp++;
        if ({i3.a, i3.b, i3.busy} !== {8'hA5, 1'b1}) begin n_bad++; $display("FAIL ign_restart_seed: got %h want 14b", {i3.a, i3.b, i3.busy}); end
        repeat (6) @(posedge clk);
    endtask

    // Random o every cycle; the model picks the value present in each SAMPLE cycle.
    task automatic test_random();
        localparam int CNT = 5, L = 4, N = CNT * L + 1;
        logic [7:0]  ov [1:N];
        logic [7:0]  l;
        logic [15:0] s;
        int busy_n, done_at;
        for (int rep = 0; rep < 2; rep++) begin
            busy_n = 0; done_at = -1; l = 8'h3B;
            @(negedge clk); i5.start = 1'b1;
            @(posedge clk); #1; i5.start = 1'b0;
            for (int c = 1; c <= N; c++) begin
                if (c > 1) begin @(posedge clk); #1; end
                if (i5.busy) busy_n++;
                if (i5.done && done_at < 0) done_at = c;
                if ((c - 1) % L == 0 && c < N) begin
                    n_cmp++;
                    if ({i5.a, i5.b} !== l) begin n_bad++; $display("FAIL rand_ab c%0d: got %h want %h", c, {i5.a, i5.b}, l); end
                    l = lfsr_step(l);
                end
                @(negedge clk);
                i5.o = 8'($urandom);
                ov[c] = i5.o;
            end
            s = 16'h0000;
            for (int k = 1; k <= CNT; k++) s = misr_step(s, ov[k * L]);
            n_cmp++;
            if (i5.sig !== s) begin n_bad++; $display("FAIL rand_sig r%0d: got %h want %h", rep, i5.sig, s); end
            n_cmp++;
            if (i5.vec_cnt !== 8'(CNT)) begin n_bad++; $display("FAIL rand_cnt r%0d: got %0d want %0d", rep, i5.vec_cnt, CNT); end
            n_cmp++;
            if (busy_n !== CNT * L || done_at !== CNT * L + 1) begin
                n_bad++; $display("FAIL rand_timing r%0d: got busy %0d done %0d want %0d %0d", rep, busy_n, done_at, CNT * L, CNT * L + 1);
            end
        end
    endtask

    // Golden run, aborted run (reset in vector 5), then a rerun that must match golden.
    task automatic test_reset_midrun();
        logic [7:0]  ot [16];
        logic [15:0] s, gold;
        int done_n;
        s = 16'h0000;
        for (int k = 0; k < 16; k++) begin
            ot[k] = 8'($urandom);
            s = misr_step(s, ot[k]);
        end
        for (int pass = 0; pass < 3; pass++) begin
            done_n = 0;
            @(negedge clk); i4.start = 1'b1;
            @(posedge clk); #1; i4.start = 1'b0;
            for (int c = 1; c <= 49; c++) begin
                if (c > 1) begin @(posedge clk); #1; end
                if (i4.done) done_n++;
                if (pass == 1 && c == 14) break;
                @(negedge clk);
                i4.o = ot[(c - 1) / 3 < 16 ? (c - 1) / 3 : 15];
            end
            if (pass == 1) begin
                #2; rst_n = 1'b0;
                #1;
                n_cmp++;
                if ({i4.busy, i4.done, i4.sig, i4.vec_cnt, i4.a, i4.b} !== {2'b00, 24'h0, 8'hA5}) begin
                    n_bad++; $display("FAIL midrun_rst_vals: got %h want 0000a5", {i4.busy, i4.done, i4.sig, i4.vec_cnt, i4.a, i4.b});
                end
                @(negedge clk); rst_n = 1'b1;
                for (int c = 0; c < 6; c++) begin
                    @(posedge clk); #1;
                    if (i4.done) done_n++;
                end
                n_cmp++;
                if (done_n !== 0) begin n_bad++; $display("FAIL midrun_no_done: got %0d want 0", done_n); end
            end else begin
                if (pass == 0) gold = i4.sig;
                n_cmp++;
                if (i4.sig !== s) begin n_bad++; $display("FAIL midrun_sig p%0d: got %h want %h", pass, i4.sig, s); end
                n_cmp++;
                if (done_n !== 1) begin n_bad++; $display("FAIL midrun_done p%0d: got %0d want 1", pass, done_n); end
            end
        end
        n_cmp++;
        if (i4.sig !== gold) begin n_bad++; $display("FAIL midrun_vs_golden: got %h want %h", i4.sig, gold); end
    endtask

    initial begin
        n_cmp = 0; n_bad = 0;
        rst_n = 1'b0;
        i1.start = 1'b0; i2.start = 1'b0; i3.start = 1'b0; i4.start = 1'b0; i5.start = 1'b0;
        i1.o = 8'h00; i2.o = 8'h00; i3.o = 8'h00; i4.o = 8'h00; i5.o = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        test_reset();
        test_single();
        test_two();
        test_settle();
        test_start_ignored();
        test_random();
        test_reset_midrun();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
